// File: rtl/mz80k_uart_pkg.sv
// Shared UART definitions for the MZ-80 serial link (transmitter and receiver).
package mz80k_uart_pkg;

    // Transmitter frame states; PARITY is only reachable when parity is built in.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int UART_DATA_BITS = 8;

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int unsigned default_baud_div(input int unsigned clk_hz,
                                                     input int unsigned baud);
        return (clk_hz + (baud / 2)) / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with registered full/empty/level flags.
// The head entry is presented combinationally (show-ahead), so a pop
// consumes rd_data on the same edge that rd_en is sampled.
module uart_sync_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          push;
    logic          pop;

    // A write while full is dropped; the writer sees full and retries.
    assign push = wr_en && !full_q;
    assign pop  = rd_en && !empty_q;

    // Next pointers, level and flags; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        full_d  = (level_d == (AW + 1)'(DEPTH));
        empty_d = (level_d == '0);
    end

    // Pointer and flag registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes are queued in uart_sync_fifo and sent
// 8N1 LSB first on uart_tx, frames back to back while the queue has data.
// Build option UART_TX_PARITY_EN inserts an even-parity bit (8E1 frames).
module uart_tx_fifo
    import mz80k_uart_pkg::*;
#(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_sys,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  LAST_BIT    = 3'(UART_DATA_BITS - 1);

    tx_state_t   state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    logic                          fifo_rd_en;
    logic [7:0]                    fifo_rd_data;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level_w;
    logic                          baud_tick;
    logic                          load_frame;

    uart_sync_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .wr_en   (tx_valid),
        .wr_data (tx_data),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level_w)
    );

    // The last cycle of every bit period is where the FSM advances.
    assign baud_tick = (baud_cnt_q == 16'd0);

    // Frame sequencing: next state, bit timing, shift register and line level.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        load_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        if (state_q != IDLE) begin
            baud_cnt_d = baud_tick ? BAUD_RELOAD : (baud_cnt_q - 16'd1);
        end

        case (state_q)
            IDLE: begin
                load_frame = !fifo_empty;
            end
            START: begin
                if (baud_tick) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
                        tx_d      = parity_q;
`else
                        state_d   = STOP;
                        tx_d      = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    if (!fifo_empty) begin
                        load_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Popping the head starts a new frame from IDLE or straight out of STOP.
        if (load_frame) begin
            state_d    = START;
            shift_d    = fifo_rd_data;
            baud_cnt_d = BAUD_RELOAD;
            bit_cnt_d  = 3'd0;
            tx_d       = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d   = ^fifo_rd_data;
`endif
        end
    end

    assign fifo_rd_en = load_frame;

    // FSM and datapath registers; reset aborts any frame and parks the line high.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_cnt_q <= 16'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign uart_tx    = tx_q;
    assign tx_ready   = !fifo_full;
    assign fifo_level = fifo_level_w;
    assign busy       = (state_q != IDLE) || (fifo_level_w != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (BAUD_DIV=4, FIFO_DEPTH=4).
// Build with +define+UART_TX_PARITY_EN to exercise 8E1 frames.
module tb_uart_tx_fifo;

    localparam int BAUD_DIV   = 4;
    localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * BAUD_DIV;

    logic       clk_sys  = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       uart_tx;
    logic       busy;
    logic [2:0] fifo_level;

    int cyc     = 0;
    int err_cnt = 0;
    int chk_cnt = 0;
    int acc_cyc [6];

    uart_tx_fifo #(
        .BAUD_DIV   (BAUD_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    // Expected line level for bit slot k of a frame carrying d.
    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic check_idle(input string tag);
        check_val({tag, "_uart_tx"}, uart_tx, 1);
        check_val({tag, "_ready"}, tx_ready, 1);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_level"}, fifo_level, 0);
    endtask

    // Called at the first sample of the start bit; checks every cycle of the frame.
    task automatic check_frame(input logic [7:0] d);
        for (int i = 0; i < FRAME_CYC; i++) begin
            check_val($sformatf("frame_%02h_bit%0d", d, i / BAUD_DIV), uart_tx,
                      frame_bit(d, i / BAUD_DIV));
            if (i == FRAME_CYC - 1) check_val("frame_busy_last", busy, 1);
            tick();
        end
        $display("frame %02h checked over %0d cycles", d, FRAME_CYC);
    endtask

    // Mid-bit samples against a hand-written bit vector (bit 0 = start bit).
    task automatic check_mid_samples(input string tag, input logic [10:0] exp_bits);
        for (int i = 0; i < FRAME_CYC; i++) begin
            if (i % BAUD_DIV == 2) check_val($sformatf("%s_s%0d", tag, i / BAUD_DIV), uart_tx, exp_bits[i / BAUD_DIV]);
            if (i == FRAME_CYC - 1) check_val({tag, "_busy_last"}, busy, 1);
            tick();
        end
        $display("%s samples checked", tag);
    endtask

    initial begin
        logic [10:0] exp55;
        // --- reset and idle ---
        tick();
        check_idle("in_reset");
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_idle("idle");
        end
        $display("reset/idle checked");

        // --- single byte 0x55 ---
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check_val("p55_line_before", uart_tx, 1);
        check_val("p55_level", fifo_level, 1);
        check_val("p55_busy", busy, 1);
        tick();
`ifdef UART_TX_PARITY_EN
        exp55 = 11'b10010101010;
`else
        exp55 = 11'b01010101010;
`endif
        check_mid_samples("p55", exp55);
        check_idle("p55_end");

        // --- six bytes with tx_valid held ---
        fork
            begin : pusher3
                bit ok;
                int n;
                for (int b = 1; b <= 6; b++) begin
                    tx_data  = 8'(b);
                    tx_valid = 1'b1;
                    n = 0;
                    do begin
                        ok = tx_ready;
                        tick();
                        n++;
                    end while (!ok && n < 300);
                    if (!ok) check_val("push_timeout", 0, 1);
                    acc_cyc[b-1] = cyc;
                    if (b == 5) begin
                        check_val("t3_ready_full", tx_ready, 0);
                        check_val("t3_level_full", fifo_level, 4);
                    end
                end
                tx_valid = 1'b0;
                $display("six pushes accepted");
            end
            begin : checker3
                tick();
                check_val("t3_line_e1", uart_tx, 1);
                tick();
                for (int k = 1; k <= 6; k++) check_frame(8'(k));
                check_idle("t3_end");
            end
        join
        check_val("t3_acc5_gap", 32'(acc_cyc[4] - acc_cyc[0]), 4);
        check_val("t3_acc6_gap", 32'(acc_cyc[5] - acc_cyc[0]), 32'(FRAME_CYC + 2));

        // --- push on the same edge as a pop at level 2 ---
        fork
            begin : pusher4
                tx_valid = 1'b1;
                tx_data  = 8'h11;
                tick();
                tx_data  = 8'h22;
                tick();
                tx_data  = 8'h33;
                tick();
                tx_valid = 1'b0;
                check_val("t4_level_pre", fifo_level, 2);
                repeat (FRAME_CYC - 2) tick();
                check_val("t4_level_before", fifo_level, 2);
                tx_data  = 8'h44;
                tx_valid = 1'b1;
                tick();
                tx_valid = 1'b0;
                check_val("t4_level_same", fifo_level, 2);
                $display("simultaneous push/pop done");
            end
            begin : checker4
                tick();
                tick();
                check_frame(8'h11);
                check_frame(8'h22);
                check_frame(8'h33);
                check_frame(8'h44);
                check_idle("t4_end");
            end
        join

        // --- reset during data bit 3 of 0xA3 ---
        tx_valid = 1'b1;
        tx_data  = 8'hA3;
        tick();
        tx_data  = 8'h77;
        tick();
        tx_valid = 1'b0;
        repeat (17) tick();
        check_val("t5_bit3", uart_tx, 0);
        check_val("t5_level", fifo_level, 1);
        reset = 1'b1;
        tick();
        check_val("t5_line_after_rst", uart_tx, 1);
        check_val("t5_level_after_rst", fifo_level, 0);
        check_val("t5_busy_after_rst", busy, 0);
        check_val("t5_ready_after_rst", tx_ready, 1);
        reset = 1'b0;
        tick();
        check_idle("t5_idle");
        $display("mid-frame reset done");
        tx_data  = 8'h0F;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        check_frame(8'h0F);
        check_idle("t5_end");

`ifdef UART_TX_PARITY_EN
        // --- parity frame for 0x07: data 1,1,1,0,0,0,0,0 then parity 1, stop ---
        tx_data  = 8'h07;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        check_mid_samples("par07", 11'b11000001110);
        check_idle("par07_end");
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
